// File: rtl/tugemm_pkg.sv
// Shared constants, state encoding and lane indexing for the tuGEMM_8x8 result decoder.
package tugemm_pkg;
  localparam int unsigned N     = 8;
  localparam int unsigned OUT_W = 19;
  localparam int unsigned LANES = N * N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Lane i carries result element (row i/N, col i%N).
  function automatic int unsigned lane_idx(input int unsigned row, input int unsigned col);
    return row * N + col;
  endfunction
endpackage

// File: rtl/tu_updown_counter.sv
// One signed up/down lane counter. With TU_DEC_SAT_EN defined the count saturates at the
// two's complement limits and flags the refused step; otherwise it wraps modulo 2^W.
module tu_updown_counter #(
  parameter int unsigned W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         dn,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         sat_hit
);
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_V  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V  = {1'b1, {(W-1){1'b0}}};

  logic [W-1:0] count_r;
  logic [W-1:0] count_nxt_s;
  logic         sat_hit_s;

`ifdef TU_DEC_SAT_EN
  assign sat_hit_s = en & (dn ? (count_r == MIN_V) : (count_r == MAX_V));
`else
  assign sat_hit_s = 1'b0;
`endif

  // Next count: clear, one step up/down, or hold (a saturated step is a hold).
  always_comb begin
    count_nxt_s = count_r;
    if (clr) begin
      count_nxt_s = ZERO_V;
    end else if (en && !sat_hit_s) begin
      count_nxt_s = dn ? (count_r - ONE_V) : (count_r + ONE_V);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= ZERO_V;
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count     = count_r;
  assign count_nxt = count_nxt_s;
  assign sat_hit   = sat_hit_s;
endmodule

// File: rtl/tu_result_decoder.sv
// Integrates N*N temporal-unary pulse/sign streams into signed counts and publishes them
// as one packed result vector at end of frame. Optional feature macro: TU_DEC_SAT_EN.
module tu_result_decoder
  import tugemm_pkg::*;
#(
  parameter int unsigned W = OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LANES-1:0]   pulse,
  input  logic [LANES-1:0]   sign,
  input  logic               last,
  output logic [LANES*W-1:0] result,
  output logic               busy,
  output logic               done,
  output logic               ovf
);
  state_e             state_r;
  logic [LANES*W-1:0] result_r;
  logic               busy_r;
  logic               done_r;
  logic               clr_s;
  logic               acc_s;
  logic [LANES*W-1:0] count_nxt_s;
  logic [LANES*W-1:0] count_unused_s;
  logic [LANES-1:0]   sat_hit_s;

  assign clr_s = (state_r == IDLE) & start;
  assign acc_s = (state_r == ACCUM);

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int unsigned LI = lane_idx(r, c);
      tu_updown_counter #(.W(W)) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_s),
        .en        (acc_s & pulse[LI]),
        .dn        (sign[LI]),
        .count     (count_unused_s[LI*W +: W]),
        .count_nxt (count_nxt_s[LI*W +: W]),
        .sat_hit   (sat_hit_s[LI])
      );
    end
  end

  // Frame FSM; result captures the counters' post-last values so it lands with done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      result_r <= {(LANES*W){1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ACCUM: begin
          if (last) begin
            state_r  <= DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= count_nxt_s;
          end else begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef TU_DEC_SAT_EN
  logic ovf_r;

  // Sticky overflow: any refused step sets it, an accepted start clears it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (clr_s) begin
      ovf_r <= 1'b0;
    end else if (acc_s && (|sat_hit_s)) begin
      ovf_r <= 1'b1;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`else
  logic sat_unused_s;
  assign sat_unused_s = |sat_hit_s;
  assign ovf          = 1'b0;
`endif

  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;
endmodule
